// File: rtl/base_arealign_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : base_arealign_multi_if
//  Description : Handshake/data bundle for the advance/delayed re-aligner.
//                The upstream side uses i_*, the downstream side uses o_*.
//  Revision    : 1.0  initial release
// ============================================================================
interface base_arealign_multi_if #(
    parameter int ADV_WIDTH = 1,
    parameter int DEL_WIDTH = 1
);
    logic                 i_v;
    logic [ADV_WIDTH-1:0] i_d_adv;
    logic [DEL_WIDTH-1:0] i_d_del;
    logic                 i_r;
    logic                 o_v;
    logic [ADV_WIDTH-1:0] o_d_adv;
    logic [DEL_WIDTH-1:0] o_d_del;
    logic                 o_r;

    // Environment side: drives the upstream beat and the downstream ready.
    modport master (
        output i_v, i_d_adv, i_d_del, o_r,
        input  i_r, o_v, o_d_adv, o_d_del
    );

    // Re-aligner side.
    modport slave (
        input  i_v, i_d_adv, i_d_del, o_r,
        output i_r, o_v, o_d_adv, o_d_del
    );
endinterface
`default_nettype wire

// File: rtl/base_arealign_multi.sv
`default_nettype none
// ============================================================================
//  Module      : base_arealign_multi
//  Description : Re-aligns advance data (present on the accepting cycle) with
//                delayed data (arriving DEL_LAT cycles later) so both halves
//                leave together on the output handshake. Two circular FIFOs
//                of DEPTH entries; delayed data bypasses its FIFO when empty.
//  Revision    : 1.0  initial release
// ============================================================================
module base_arealign_multi #(
    parameter int ADV_WIDTH = 1,
    parameter int DEL_WIDTH = 1,
    parameter int DEL_LAT   = 1,
    parameter int DEPTH     = 2
) (
    input  wire logic           clk,
    input  wire logic           reset,
    base_arealign_multi_if.slave bus
);

    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    // Storage rounded up to the pointer range so any pointer value indexes it.
    localparam int MEM_N = 1 << PW;
    localparam logic [PW-1:0] C_LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [DEL_LAT-1:0]   del_sr_q, del_sr_d;
    logic [PW-1:0]        adv_wp_q, adv_wp_d, adv_rp_q, adv_rp_d;
    logic [PW-1:0]        del_wp_q, del_wp_d, del_rp_q, del_rp_d;
    logic [CW-1:0]        adv_cnt_q, adv_cnt_d, del_cnt_q, del_cnt_d;

    logic [ADV_WIDTH-1:0] adv_mem [MEM_N];
    logic [DEL_WIDTH-1:0] del_mem [MEM_N];

    logic w_adv_ne, w_del_ne, w_del_arr, w_i_r, w_o_v;
    logic w_din_act, w_dout_act, w_del_wr, w_del_rd;

    // Pointer advance with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == C_LAST) ? '0 : p + PW'(1);
    endfunction

    // Handshake events; i_r depends on registered state only.
    always_comb begin
        w_adv_ne   = (adv_cnt_q != '0);
        w_del_ne   = (del_cnt_q != '0);
        w_del_arr  = del_sr_q[DEL_LAT-1];
        w_i_r      = (adv_cnt_q < C_DEPTH);
        w_o_v      = w_adv_ne & (w_del_ne | w_del_arr);
        w_din_act  = bus.i_v & w_i_r;
        w_dout_act = w_o_v & bus.o_r;
        // Arriving delayed data skips the FIFO when it leaves this same cycle.
        w_del_wr   = w_del_arr & ~(~w_del_ne & w_dout_act);
        w_del_rd   = w_dout_act & w_del_ne;
    end

    assign bus.i_r     = w_i_r;
    assign bus.o_v     = w_o_v;
    assign bus.o_d_adv = adv_mem[adv_rp_q];
    assign bus.o_d_del = w_del_ne ? del_mem[del_rp_q] : bus.i_d_del;

    // Next-state for arrival shift register, pointers and occupancy counts.
    always_comb begin
        del_sr_d    = del_sr_q;
        del_sr_d[0] = w_din_act;
        for (int i = 1; i < DEL_LAT; i++) begin
            del_sr_d[i] = del_sr_q[i-1];
        end

        adv_wp_d  = w_din_act  ? f_inc(adv_wp_q) : adv_wp_q;
        adv_rp_d  = w_dout_act ? f_inc(adv_rp_q) : adv_rp_q;
        del_wp_d  = w_del_wr   ? f_inc(del_wp_q) : del_wp_q;
        del_rp_d  = w_del_rd   ? f_inc(del_rp_q) : del_rp_q;

        adv_cnt_d = adv_cnt_q;
        if (w_din_act && !w_dout_act) begin
            adv_cnt_d = adv_cnt_q + CW'(1);
        end else if (!w_din_act && w_dout_act) begin
            adv_cnt_d = adv_cnt_q - CW'(1);
        end

        del_cnt_d = del_cnt_q;
        if (w_del_wr && !w_del_rd) begin
            del_cnt_d = del_cnt_q + CW'(1);
        end else if (!w_del_wr && w_del_rd) begin
            del_cnt_d = del_cnt_q - CW'(1);
        end
    end

    // Control state; reset discards buffered and in-flight beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            del_sr_q  <= '0;
            adv_wp_q  <= '0;
            adv_rp_q  <= '0;
            del_wp_q  <= '0;
            del_rp_q  <= '0;
            adv_cnt_q <= '0;
            del_cnt_q <= '0;
        end else begin
            del_sr_q  <= del_sr_d;
            adv_wp_q  <= adv_wp_d;
            adv_rp_q  <= adv_rp_d;
            del_wp_q  <= del_wp_d;
            del_rp_q  <= del_rp_d;
            adv_cnt_q <= adv_cnt_d;
            del_cnt_q <= del_cnt_d;
        end
    end

    // Data storage is not reset; contents only matter behind the counts.
    always_ff @(posedge clk) begin
        if (w_din_act) begin
            adv_mem[adv_wp_q] <= bus.i_d_adv;
        end
        if (w_del_wr) begin
            del_mem[del_wp_q] <= bus.i_d_del;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_base_arealign_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_base_arealign_multi
//  Description : Directed bench for base_arealign_multi across several
//                DEL_LAT/DEPTH configurations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_base_arealign_multi;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    base_arealign_multi_if #(.ADV_WIDTH(8), .DEL_WIDTH(8)) if1 ();
    base_arealign_multi_if #(.ADV_WIDTH(8), .DEL_WIDTH(8)) if2 ();
    base_arealign_multi_if #(.ADV_WIDTH(8), .DEL_WIDTH(8)) if3 ();
    base_arealign_multi_if #(.ADV_WIDTH(8), .DEL_WIDTH(8)) if4 ();
    base_arealign_multi_if #(.ADV_WIDTH(8), .DEL_WIDTH(8)) if5 ();

    base_arealign_multi #(.ADV_WIDTH(8), .DEL_WIDTH(8), .DEL_LAT(1), .DEPTH(2))
        u1 (.clk(clk), .reset(reset), .bus(if1));
    base_arealign_multi #(.ADV_WIDTH(8), .DEL_WIDTH(8), .DEL_LAT(3), .DEPTH(4))
        u2 (.clk(clk), .reset(reset), .bus(if2));
    base_arealign_multi #(.ADV_WIDTH(8), .DEL_WIDTH(8), .DEL_LAT(3), .DEPTH(2))
        u3 (.clk(clk), .reset(reset), .bus(if3));
    base_arealign_multi #(.ADV_WIDTH(8), .DEL_WIDTH(8), .DEL_LAT(2), .DEPTH(4))
        u4 (.clk(clk), .reset(reset), .bus(if4));
    base_arealign_multi #(.ADV_WIDTH(8), .DEL_WIDTH(8), .DEL_LAT(1), .DEPTH(1))
        u5 (.clk(clk), .reset(reset), .bus(if5));

    task automatic test_reset;
        reset = 1'b1;
        {if1.i_v, if2.i_v, if3.i_v, if4.i_v, if5.i_v} = '0;
        {if1.o_r, if2.o_r, if3.o_r, if4.o_r, if5.o_r} = '0;
        {if1.i_d_adv, if2.i_d_adv, if3.i_d_adv, if4.i_d_adv, if5.i_d_adv} = '0;
        {if1.i_d_del, if2.i_d_del, if3.i_d_del, if4.i_d_del, if5.i_d_del} = '0;
        repeat (2) @(negedge clk);
        #1;
        total++; if ({if1.o_v, if2.o_v, if3.o_v, if4.o_v, if5.o_v} !== 5'b00000) begin
            bad++; $display("FAIL rst_ov got=%b want=00000", {if1.o_v, if2.o_v, if3.o_v, if4.o_v, if5.o_v});
        end
        total++; if ({if1.i_r, if2.i_r, if3.i_r, if4.i_r, if5.i_r} !== 5'b11111) begin
            bad++; $display("FAIL rst_ir got=%b want=11111", {if1.i_r, if2.i_r, if3.i_r, if4.i_r, if5.i_r});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if ({if1.o_v, if2.o_v, if3.o_v, if4.o_v, if5.o_v} !== 5'b00000) begin
            bad++; $display("FAIL rst_rel_ov got=%b want=00000", {if1.o_v, if2.o_v, if3.o_v, if4.o_v, if5.o_v});
        end
    endtask

    // DEL_LAT=1, DEPTH=2: eight beats back to back, full throughput.
    task automatic test_back_to_back;
        logic exp_ov;
        if1.o_r = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if1.i_v     = (k < 8);
            if1.i_d_adv = 8'(k);
            if1.i_d_del = (k >= 1 && k <= 8) ? 8'(8'h80 + k - 1) : 8'h00;
            #1;
            exp_ov = (k >= 1 && k <= 8);
            total++; if (if1.i_r !== 1'b1) begin
                bad++; $display("FAIL b2b_ir c=%0d got=%b want=1", k, if1.i_r);
            end
            total++; if (if1.o_v !== exp_ov) begin
                bad++; $display("FAIL b2b_ov c=%0d got=%b want=%b", k, if1.o_v, exp_ov);
            end
            if (exp_ov) begin
                total++; if ({if1.o_d_adv, if1.o_d_del} !== {8'(k - 1), 8'(8'h80 + k - 1)}) begin
                    bad++; $display("FAIL b2b_data c=%0d got=%h/%h want=%h/%h", k,
                                    if1.o_d_adv, if1.o_d_del, 8'(k - 1), 8'(8'h80 + k - 1));
                end
            end
        end
        if1.i_v = 1'b0; if1.o_r = 1'b0; if1.i_d_del = 8'h00;
    endtask

    // DEL_LAT=3, DEPTH=4: single beat, delayed half taken through the bypass.
    task automatic test_bypass;
        logic exp_ov;
        if2.o_r = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if2.i_v     = (k == 0);
            if2.i_d_adv = (k == 0) ? 8'h05 : 8'hEE;
            if2.i_d_del = (k == 3) ? 8'h0A : 8'h33;
            #1;
            exp_ov = (k == 3);
            total++; if (if2.o_v !== exp_ov) begin
                bad++; $display("FAIL byp_ov c=%0d got=%b want=%b", k, if2.o_v, exp_ov);
            end
            if (exp_ov) begin
                total++; if ({if2.o_d_adv, if2.o_d_del} !== 16'h050A) begin
                    bad++; $display("FAIL byp_data got=%h/%h want=05/0a", if2.o_d_adv, if2.o_d_del);
                end
            end
        end
        if2.i_v = 1'b0; if2.o_r = 1'b0;
    endtask

    // DEL_LAT=3, DEPTH=2: continuous stream, i_r throttles, order kept.
    task automatic test_stream;
        int         sent = 0;
        int         recv = 0;
        int         dut_low = 0;
        int         acc_cyc [20];
        logic [7:0] sched [256];
        logic       exp_ir, exp_ov;
        for (int i = 0; i < 256; i++) sched[i] = 8'h00;
        if3.o_r = 1'b1;
        for (int cyc = 0; cyc < 200 && recv < 20; cyc++) begin
            @(negedge clk);
            if3.i_d_del = sched[cyc];
            if3.i_v     = (sent < 20);
            if3.i_d_adv = 8'(sent);
            #1;
            exp_ir = ((sent - recv) < 2);
            exp_ov = ((sent - recv) > 0) && (cyc >= acc_cyc[recv] + 3);
            if (if3.i_r === 1'b0) dut_low++;
            total++; if (if3.i_r !== exp_ir) begin
                bad++; $display("FAIL str_ir c=%0d got=%b want=%b", cyc, if3.i_r, exp_ir);
            end
            total++; if (if3.o_v !== exp_ov) begin
                bad++; $display("FAIL str_ov c=%0d got=%b want=%b", cyc, if3.o_v, exp_ov);
            end
            if (exp_ov) begin
                total++; if ({if3.o_d_adv, if3.o_d_del} !== {8'(recv), 8'hC0 ^ 8'(recv)}) begin
                    bad++; $display("FAIL str_data beat=%0d got=%h/%h want=%h/%h", recv,
                                    if3.o_d_adv, if3.o_d_del, 8'(recv), 8'hC0 ^ 8'(recv));
                end
                recv++;
            end
            if (sent < 20 && exp_ir) begin
                acc_cyc[sent]   = cyc;
                sched[cyc + 3]  = 8'hC0 ^ 8'(sent);
                sent++;
            end
        end
        total++; if (recv !== 20) begin
            bad++; $display("FAIL str_count got=%0d want=20", recv);
        end
        total++; if (dut_low == 0) begin
            bad++; $display("FAIL str_ir_low got=%0d want=>0", dut_low);
        end
        if3.i_v = 1'b0; if3.o_r = 1'b0; if3.i_d_del = 8'h00;
    endtask

    // DEPTH=4, DEL_LAT=2: backpressure holds the head, then drains in order.
    task automatic test_backpressure;
        bit         iv  [15] = '{1,1,1,1,1,1,1,1,1,1,0,0,0,0,0};
        logic [7:0] adv [15] = '{8'h10,8'h11,8'h12,8'h13,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,0,0,0,0,0};
        logic [7:0] del [15] = '{0,0,8'h20,8'h21,8'h22,8'h23,8'h55,8'h55,8'h55,8'h55,0,0,0,0,0};
        bit         orr [15] = '{0,0,0,0,0,0,0,0,0,0,1,1,1,1,1};
        bit         eir [15] = '{1,1,1,1,0,0,0,0,0,0,0,1,1,1,1};
        bit         eov [15] = '{0,0,1,1,1,1,1,1,1,1,1,1,1,1,0};
        logic [7:0] ea  [15] = '{0,0,8'h10,8'h10,8'h10,8'h10,8'h10,8'h10,8'h10,8'h10,8'h10,8'h11,8'h12,8'h13,0};
        logic [7:0] ed  [15] = '{0,0,8'h20,8'h20,8'h20,8'h20,8'h20,8'h20,8'h20,8'h20,8'h20,8'h21,8'h22,8'h23,0};
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if4.i_v = iv[c]; if4.i_d_adv = adv[c]; if4.i_d_del = del[c]; if4.o_r = orr[c];
            #1;
            total++; if (if4.i_r !== eir[c]) begin
                bad++; $display("FAIL bp_ir c=%0d got=%b want=%b", c, if4.i_r, eir[c]);
            end
            total++; if (if4.o_v !== eov[c]) begin
                bad++; $display("FAIL bp_ov c=%0d got=%b want=%b", c, if4.o_v, eov[c]);
            end
            if (eov[c]) begin
                total++; if ({if4.o_d_adv, if4.o_d_del} !== {ea[c], ed[c]}) begin
                    bad++; $display("FAIL bp_data c=%0d got=%h/%h want=%h/%h", c,
                                    if4.o_d_adv, if4.o_d_del, ea[c], ed[c]);
                end
            end
        end
        if4.i_v = 1'b0; if4.o_r = 1'b0;
    endtask

    // DEPTH=1: a full buffer never passes an input straight through.
    task automatic test_full_simultaneous;
        bit         iv  [5] = '{1,1,1,0,0};
        logic [7:0] adv [5] = '{8'h03,8'h07,8'h07,0,0};
        logic [7:0] del [5] = '{0,8'h04,0,8'h08,0};
        bit         eir [5] = '{1,0,1,0,1};
        bit         eov [5] = '{0,1,0,1,0};
        logic [7:0] ea  [5] = '{0,8'h03,0,8'h07,0};
        logic [7:0] ed  [5] = '{0,8'h04,0,8'h08,0};
        if5.o_r = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if5.i_v = iv[c]; if5.i_d_adv = adv[c]; if5.i_d_del = del[c];
            #1;
            total++; if (if5.i_r !== eir[c]) begin
                bad++; $display("FAIL full_ir c=%0d got=%b want=%b", c, if5.i_r, eir[c]);
            end
            total++; if (if5.o_v !== eov[c]) begin
                bad++; $display("FAIL full_ov c=%0d got=%b want=%b", c, if5.o_v, eov[c]);
            end
            if (eov[c]) begin
                total++; if ({if5.o_d_adv, if5.o_d_del} !== {ea[c], ed[c]}) begin
                    bad++; $display("FAIL full_data c=%0d got=%h/%h want=%h/%h", c,
                                    if5.o_d_adv, if5.o_d_del, ea[c], ed[c]);
                end
            end
        end
        if5.i_v = 1'b0; if5.o_r = 1'b0;
    endtask

    // DEPTH=4, DEL_LAT=2: reset with three beats buffered and one in flight.
    task automatic test_reset_midstream;
        bit         iv  [5] = '{1,1,1,0,1};
        logic [7:0] adv [5] = '{8'h30,8'h31,8'h32,0,8'h33};
        logic [7:0] del [5] = '{0,0,8'h40,8'h41,8'h42};
        if4.o_r = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if4.i_v = iv[c]; if4.i_d_adv = adv[c]; if4.i_d_del = del[c];
        end
        @(negedge clk);
        if4.i_v = 1'b0; if4.i_d_del = 8'h00;
        #1;
        total++; if ({if4.o_v, if4.o_d_adv, if4.o_d_del} !== {1'b1, 8'h30, 8'h40}) begin
            bad++; $display("FAIL mrst_pre got=%b/%h/%h want=1/30/40", if4.o_v, if4.o_d_adv, if4.o_d_del);
        end
        reset = 1'b1;
        #1;
        total++; if (if4.o_v !== 1'b0) begin
            bad++; $display("FAIL mrst_ov got=%b want=0", if4.o_v);
        end
        total++; if (if4.i_r !== 1'b1) begin
            bad++; $display("FAIL mrst_ir got=%b want=1", if4.i_r);
        end
        @(negedge clk);
        reset = 1'b0; if4.i_d_del = 8'h43;
        #1;
        total++; if ({if4.o_v, if4.i_r} !== 2'b01) begin
            bad++; $display("FAIL mrst_late got=%b want=01", {if4.o_v, if4.i_r});
        end
        @(negedge clk);
        if4.i_d_del = 8'h00; if4.i_v = 1'b1; if4.i_d_adv = 8'h55; if4.o_r = 1'b1;
        #1;
        total++; if (if4.o_v !== 1'b0) begin
            bad++; $display("FAIL mrst_c7_ov got=%b want=0", if4.o_v);
        end
        @(negedge clk);
        if4.i_v = 1'b0;
        #1;
        total++; if (if4.o_v !== 1'b0) begin
            bad++; $display("FAIL mrst_c8_ov got=%b want=0", if4.o_v);
        end
        @(negedge clk);
        if4.i_d_del = 8'h66;
        #1;
        total++; if ({if4.o_v, if4.o_d_adv, if4.o_d_del} !== {1'b1, 8'h55, 8'h66}) begin
            bad++; $display("FAIL mrst_next got=%b/%h/%h want=1/55/66", if4.o_v, if4.o_d_adv, if4.o_d_del);
        end
        @(negedge clk);
        if4.i_d_del = 8'h00;
        #1;
        total++; if (if4.o_v !== 1'b0) begin
            bad++; $display("FAIL mrst_after got=%b want=0", if4.o_v);
        end
        if4.o_r = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_bypass();
        test_stream();
        test_backpressure();
        test_full_simultaneous();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
